// File: rtl/board_io_ctrl.sv
// board_io_ctrl: Avalon-MM LED / seven-segment / pushbutton peripheral with blink, debounce and edge irq.
// Define BOARD_IO_RELEASE_EDGE_EN to also capture key release edges in KEY_EDGE[8+NUM_KEY-1:8].
module board_io_ctrl #(
  parameter int NUM_LED = 10,
  parameter int NUM_HEX = 6,
  parameter int NUM_KEY = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [3:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [NUM_KEY-1:0]   KEY,
  output logic [NUM_LED-1:0]   LEDR,
  output logic [7*NUM_HEX-1:0] HEX
);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [15:0] KM = 16'((1 << NUM_KEY) - 1);
`ifdef BOARD_IO_RELEASE_EDGE_EN
  localparam logic [15:0] EDGE_BITS = KM | (KM << 8);
`else
  localparam logic [15:0] EDGE_BITS = KM;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [NUM_LED-1:0] led_data;
  logic [NUM_HEX-1:0] hex_mode, blink_hex;
  logic               blink_led;
  logic [6:0]         hex_value [NUM_HEX];
  logic [15:0]        key_edge, irq_mask, edge_set;
  logic [NUM_KEY-1:0] s1, sync, stable, accept;
  logic [DW-1:0]      db_cnt [NUM_KEY];
  logic [BW-1:0]      blink_cnt;
  logic               phase, wrap;
  logic [31:0]        rd_mux;
  logic               unused;
  assign unused = ^avs_writedata[31:17];
  assign wrap = blink_cnt == BW'(BLINK_DIV - 1);
  always_comb begin
    accept = '0;
    for (int k = 0; k < NUM_KEY; k++)
      accept[k] = sync[k] != stable[k] && db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1);
    edge_set = EDGE_BITS & ((16'(accept & ~sync) << 8) | 16'(accept & sync));
    rd_mux = '0;
    case (avs_address)
      4'd0: rd_mux[NUM_LED-1:0] = led_data;
      4'd1: rd_mux[NUM_HEX-1:0] = hex_mode;
      4'd2: rd_mux = (32'(blink_led) << 16) | 32'(blink_hex);
      4'd3: rd_mux[NUM_KEY-1:0] = stable;
      4'd4: rd_mux[15:0] = key_edge;
      4'd5: rd_mux[15:0] = irq_mask;
      default: for (int i = 0; i < NUM_HEX; i++) if (avs_address == 4'(6 + i)) rd_mux[6:0] = hex_value[i];
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      led_data     <= '0;
      hex_mode     <= '1;
      blink_hex    <= '0;
      blink_led    <= 1'b0;
      key_edge     <= '0;
      irq_mask     <= '0;
      s1           <= '0;
      sync         <= '0;
      stable       <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
      LEDR         <= '0;
      HEX          <= '1;
      for (int i = 0; i < NUM_HEX; i++) hex_value[i] <= '0;
      for (int k = 0; k < NUM_KEY; k++) db_cnt[k] <= '0;
    end else begin
      s1     <= ~KEY;
      sync   <= s1;
      stable <= stable ^ accept;
      for (int k = 0; k < NUM_KEY; k++)
        db_cnt[k] <= (sync[k] == stable[k] || accept[k]) ? '0 : db_cnt[k] + 1'b1;
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      phase     <= phase ^ wrap;
      // set wins over a simultaneous W1C on the same bit
      key_edge <= (key_edge & ~((avs_write && avs_address == 4'd4) ? avs_writedata[15:0] : 16'd0)) | edge_set;
      irq          <= |(key_edge & irq_mask);
      avs_readdata <= avs_read ? rd_mux : '0;
      LEDR         <= (blink_led && !phase) ? '0 : led_data;
      for (int i = 0; i < NUM_HEX; i++)
        HEX[7*i +: 7] <= (blink_hex[i] && !phase) ? 7'h7F : ~(hex_mode[i] ? hex_value[i] : GLYPH[hex_value[i][3:0]]);
      if (avs_write)
        case (avs_address)
          4'd0: led_data <= avs_writedata[NUM_LED-1:0];
          4'd1: hex_mode <= avs_writedata[NUM_HEX-1:0];
          4'd2: begin
            blink_hex <= avs_writedata[NUM_HEX-1:0];
            blink_led <= avs_writedata[16];
          end
          4'd5: irq_mask <= avs_writedata[15:0] & EDGE_BITS;
          default: for (int i = 0; i < NUM_HEX; i++) if (avs_address == 4'(6 + i)) hex_value[i] <= avs_writedata[6:0];
        endcase
    end
  end
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed plus randomized bench for board_io_ctrl against a behavioural model.
module tb_board_io_ctrl;
  localparam int NL = 10, NH = 6, NK = 4, D = 4, B = 8;
`ifdef BOARD_IO_RELEASE_EDGE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [15:0] KM = 16'((1 << NK) - 1);
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          reset = 1'b1, rd = 1'b0, wr = 1'b0, irq;
  logic [3:0]    addr = '0;
  logic [31:0]   wd = '0, rdata;
  logic [NK-1:0] key = '1;
  logic [NL-1:0] ledr;
  logic [7*NH-1:0] hex;
  int n_chk = 0, n_fail = 0;

  board_io_ctrl #(.NUM_LED(NL), .NUM_HEX(NH), .NUM_KEY(NK), .DEBOUNCE_CYCLES(D), .BLINK_DIV(B)) dut (
    .CLOCK_50(clk), .reset(reset), .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wd), .avs_readdata(rdata), .irq(irq), .KEY(key), .LEDR(ledr), .HEX(hex));

  logic [NL-1:0]   m_led, m_ledr;
  logic [NH-1:0]   m_hmode, m_bhex;
  logic            m_bled, m_irq, m_rdv;
  logic [6:0]      m_hval [NH];
  logic [15:0]     m_edge, m_mask;
  logic [NK-1:0]   m_state;
  logic [31:0]     m_rdata;
  logic [7*NH-1:0] m_hex;
  int              m_n;
  logic [NK-1:0]   m_kq [$];
  logic [NK-1:0]   m_sq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [3:0] a);
    int i = int'(a);
    case (i)
      0: return 32'(m_led);
      1: return 32'(m_hmode);
      2: return (32'(m_bled) << 16) | 32'(m_bhex);
      3: return 32'(m_state);
      4: return 32'(m_edge);
      5: return 32'(m_mask);
      default: return (i >= 6 && i < 6 + NH) ? 32'(m_hval[i-6]) : 32'd0;
    endcase
  endfunction

  // One clock edge of the reference: outputs come from the state before the edge.
  task automatic model_step();
    logic [15:0] set, clr;
    logic [NK-1:0] s;
    bit ph, all;
    if (reset) begin
      m_led = '0; m_hmode = '1; m_bhex = '0; m_bled = 0; m_edge = '0; m_mask = '0;
      m_state = '0; m_irq = 0; m_rdv = 0; m_rdata = '0; m_ledr = '0; m_hex = '1; m_n = 0;
      for (int i = 0; i < NH; i++) m_hval[i] = '0;
      m_kq = '{NK'(0), NK'(0)};
      m_sq.delete();
      return;
    end
    ph = ((m_n / B) % 2) == 1;
    m_ledr = (m_bled && !ph) ? '0 : m_led;
    for (int i = 0; i < NH; i++)
      m_hex[7*i +: 7] = (m_bhex[i] && !ph) ? 7'h7F : ~(m_hmode[i] ? m_hval[i] : GLY[m_hval[i][3:0]]);
    m_irq = |(m_edge & m_mask);
    m_rdv = rd;
    if (rd) m_rdata = m_reg(addr);
    m_kq.push_back(~key);
    s = m_kq.pop_front();
    m_sq.push_back(s);
    if (m_sq.size() > D) void'(m_sq.pop_front());
    set = '0;
    for (int k = 0; k < NK; k++)
      if (m_sq.size() == D) begin
        all = 1;
        foreach (m_sq[j]) if (m_sq[j][k] == m_state[k]) all = 0;
        if (all) begin
          m_state[k] = ~m_state[k];
          if (m_state[k]) set[k] = 1'b1;
          else if (REL) set[8+k] = 1'b1;
        end
      end
    clr = (wr && addr == 4'd4) ? wd[15:0] : 16'd0;
    if (wr) begin
      if (addr == 4'd0) m_led = wd[NL-1:0];
      if (addr == 4'd1) m_hmode = wd[NH-1:0];
      if (addr == 4'd2) begin m_bhex = wd[NH-1:0]; m_bled = wd[16]; end
      if (addr == 4'd5) m_mask = wd[15:0] & (KM | (REL ? KM << 8 : 16'd0));
      for (int i = 0; i < NH; i++) if (int'(addr) == 6 + i) m_hval[i] = wd[6:0];
    end
    m_edge = (m_edge & ~clr) | set;
    m_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ledr", 64'(ledr), 64'(m_ledr));
    chk("hex", 64'(hex), 64'(m_hex));
    chk("irq", 64'(irq), 64'(m_irq));
    if (m_rdv) chk($sformatf("rdata@%0d", addr), 64'(rdata), 64'(m_rdata));
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    wr = 1; addr = a; wd = d;
    tick();
    wr = 0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] v);
    rd = 1; addr = a;
    tick();
    v = rdata;
    rd = 0;
  endtask

  initial begin
    logic [31:0] v;
    int on_cnt, d1_bad, r;
    repeat (3) tick();
    reset = 0;
    chk("rst_ledr", 64'(ledr), 0);
    chk("rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
    chk("rst_irq", 64'(irq), 0);
    for (int a = 0; a < 16; a++) begin
      rd_reg(4'(a), v);
      chk($sformatf("rst_reg%0d", a), 64'(v), a == 1 ? 64'h3F : 64'h0);
    end
    wr_reg(1, 0);
    wr_reg(6, 32'hA);
    wr_reg(7, 32'h3);
    tick();
    chk("hex0_A", 64'(hex[6:0]), 64'(7'b0001000));
    chk("hex1_3", 64'(hex[13:7]), 64'(7'b0110000));
    wr_reg(0, 32'h3FF);
    wr_reg(2, 32'h10001);
    on_cnt = 0; d1_bad = 0;
    repeat (32) begin
      tick();
      if (ledr == 10'h3FF) on_cnt++;
      if (hex[13:7] != 7'b0110000) d1_bad++;
    end
    chk("led_on_cycles", 64'(on_cnt), 16);
    chk("hex1_steady", 64'(d1_bad), 0);
    key[2] = 0;
    repeat (3) tick();
    key[2] = 1;
    repeat (10) tick();
    rd_reg(3, v); chk("glitch_state", 64'(v), 0);
    rd_reg(4, v); chk("glitch_edge", 64'(v), 0);
    wr_reg(5, 32'h4);
    key[2] = 0;
    repeat (6) tick();
    chk("irq_before", 64'(irq), 0);
    rd_reg(3, v); chk("press_state", 64'(v), 4);
    chk("irq_after", 64'(irq), 1);
    rd_reg(4, v); chk("press_edge", 64'(v), 4);
    key[0] = 0;
    repeat (5) tick();
    wr_reg(4, 32'h4);
    rd_reg(4, v); chk("clr_other_edge", 64'(v), 1);
    key[3] = 0;
    repeat (5) tick();
    wr_reg(4, 32'h8);
    rd_reg(4, v); chk("set_wins", 64'(v), 9);
    key[1] = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_ledr", 64'(ledr), 0);
    chk("midrst_irq", 64'(irq), 0);
    repeat (5) tick();
    rd_reg(3, v); chk("rst_redeb_early", 64'(v), 0);
    rd_reg(3, v); chk("rst_redeb_state", 64'(v), 4'hF);
    rd_reg(4, v); chk("rst_redeb_edge", 64'(v), 4'hF);
    wr_reg(4, 32'hFFFF);
    key[1] = 1;
    repeat (7) tick();
    rd_reg(4, v); chk("release_bit9", 64'(v[9]), 64'(REL));
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      wr = r < 8;
      rd = r >= 8 && r < 25;
      addr = 4'($urandom_range(0, 15));
      wd = $urandom;
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 7) == 0) key[k] = ~key[k];
      reset = $urandom_range(0, 399) == 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised Avalon-MM slave peripheral that replaces the plain LED PIO export. It drives NUM_LED LEDs and NUM_HEX seven-segment displays.
- Adds per-display hex decode or raw-segment mode, and per-output blinking.
- Debounces NUM_KEY pushbuttons, with press-edge capture and a maskable interrupt.
- Sits inside the qsys fabric, clocked from the system PLL; its conduits go to the LEDR, HEX and KEY pins in the top-level.

Parameters:
NUM_LED, 10, LED count (1..16)
NUM_HEX, 6, seven-segment display count (1..10)
NUM_KEY, 4, pushbutton count (1..8)
DEBOUNCE_CYCLES, 500000, stable cycles needed to accept a key change (10 ms at 50 MHz); must be >=2
BLINK_DIV, 25000000, cycles per blink phase toggle; must be >=2

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
avs_address  in  4  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
irq  out  1  interrupt, level, active-high
KEY  in  NUM_KEY  raw pushbuttons, active-low, asynchronous to CLOCK_50
LEDR  out  NUM_LED  LED drive, active-high
HEX  out  7*NUM_HEX  segments, active-low; display i occupies bits [7i+6:7i]

Behaviour:
- Register map (word address):
  - 0 LED_DATA, RW, bits [NUM_LED-1:0]
  - 1 HEX_MODE, RW; bit i=1 selects raw mode for display i, bit i=0 selects hex decode
  - 2 BLINK_EN, RW; bits [NUM_HEX-1:0] per display, bit 16 for all LEDs
  - 3 KEY_STATE, RO; debounced level, 1=pressed
  - 4 KEY_EDGE, W1C; bits [NUM_KEY-1:0] press edges
  - 5 IRQ_MASK, RW, bits [NUM_KEY-1:0]
  - 6..6+NUM_HEX-1 HEX_VALUE i, RW; bits [6:0] are raw segments, active-high (1=lit); bits [3:0] give the nibble in hex mode
  - Unmapped addresses and unimplemented bits read 0; writes to them are ignored.
- Reads: avs_readdata is valid the cycle after avs_read (latency 1). There is no waitrequest. A write takes effect on the next edge.
- Reset values: all registers 0 except HEX_MODE = all 1. Result after reset: LEDR=0, HEX all 1 (blank), irq=0, avs_readdata=0, blink counter 0, phase 0, KEY_STATE 0.
- Hex decode: standard 0-F glyphs (b and d lowercase). The decoded segments are active-high internally; the HEX output is the bitwise inverse.
- Blink:
  - A free-running counter counts 0..BLINK_DIV-1 and wraps. On each wrap, phase toggles.
  - When phase=0, every display with its blink bit set outputs 7'h7F, and LEDR outputs 0 if BLINK_EN[16] is set. When phase=1, outputs are normal.
  - Outputs are registered: one cycle from a register or phase change to the pin.
- Debounce (per key):
  - KEY is inverted, then passed through a 2-flop synchroniser to give sync.
  - If sync == stable, the counter clears. Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is rejected.
  - Press latency from KEY to KEY_STATE = 2 + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - A stable 0->1 transition sets the corresponding KEY_EDGE bit. Writing 1 to a bit clears it.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- irq: registered; irq <= |(KEY_EDGE & IRQ_MASK). It asserts one cycle after the bit sets and deasserts one cycle after it is cleared or masked.
- Reset asserted mid-operation: every state returns to its reset value on that edge, including any in-progress debounce count. A pressed key that is still held is re-accepted after the full debounce period.

Optional Feature:
- Macro: BOARD_IO_RELEASE_EDGE_EN.
- Defined: stable 1->0 transitions set KEY_EDGE bits [8+NUM_KEY-1:8], which are W1C with set-wins priority. IRQ_MASK bits [8+NUM_KEY-1:8] gate these bits into irq.
- Undefined: those bits are not implemented, read 0, and never raise irq.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, BLINK_DIV=8.
- Reset, then read addresses 0..15 -> LEDR=0, HEX all 1; read HEX_MODE=0x3F, all other registers 0, irq=0.
- Write HEX_MODE=0, HEX_VALUE0=0xA, HEX_VALUE1=0x3 -> HEX[6:0]=7'b0001000, HEX[13:7]=7'b0110000 one cycle after the write.
- Write LED_DATA=0x3FF, BLINK_EN=0x10001 -> LEDR alternates 0 and 0x3FF every 8 cycles; display 0 toggles between blank and glyph; display 1 stays steady.
- KEY[2] low for 3 cycles -> no change in KEY_STATE or KEY_EDGE. KEY[2] held low -> KEY_STATE=0x4 after 6 cycles; KEY_EDGE=0x4; with IRQ_MASK=0x4, irq=1 one cycle later.
- Write KEY_EDGE=0x4 in the same cycle as a new KEY[0] edge -> KEY_EDGE=0x1, irq follows the mask. Assert reset while a key is mid-debounce -> all registers return to reset values, then KEY_STATE asserts 6 cycles after reset deasserts.
- With BOARD_IO_RELEASE_EDGE_EN defined: release KEY[1] after acceptance -> KEY_EDGE bit 9 sets. Without the macro -> bit 9 reads 0.
